// File: rtl/ibex_data_mem_responder.sv
// Word-organised, byte-enabled data RAM answering the core's req/gnt/rvalid data bus.
// Latency: grant after GNT_DELAY cycles of held req; response RVALID_LATENCY cycles after grant.
// Backpressure: none on responses; requests stall only through the programmable grant delay.
module ibex_data_mem_responder #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned RVALID_LATENCY = 1,
  parameter int unsigned GNT_DELAY      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  // Span is computed one bit wider so the range compare stays exact for large memories.
  localparam logic [32:0] SPAN        = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  GNT_DELAY_C = 4'(GNT_DELAY);

  logic [3:0]                wait_cnt;
  logic [31:0]               offset;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic [31:0]               mem [DEPTH_WORDS];
  logic                      rsp_err;
  logic [31:0]               rsp_rdata;
  logic [RVALID_LATENCY-1:0] stg_vld;
  logic [RVALID_LATENCY-1:0] stg_err;
  logic [31:0]               stg_rdata [RVALID_LATENCY];

  assign data_gnt_o = data_req_i && (wait_cnt == GNT_DELAY_C);

  // Address is rebased first; wrap-around below BASE_ADDR lands far out of range.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;
  assign idx      = offset[IDX_W+1:2];

  // Grant delay counter: counts stalled request cycles, restarts on grant or dropped req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!data_req_i || data_gnt_o) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Byte-lane store on the grant edge; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response payload captured at grant: old word for loads, zero for stores and errors.
  always_comb begin
    rsp_err   = data_gnt_o && !in_range;
    rsp_rdata = '0;
    if (data_gnt_o && !data_we_i && in_range) begin
      rsp_rdata = mem[idx];
    end
  end

  // Fixed-latency response shift register; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      stg_err <= '0;
      for (int i = 0; i < RVALID_LATENCY; i++) begin
        stg_rdata[i] <= '0;
      end
    end else begin
      stg_vld[0]   <= data_gnt_o;
      stg_err[0]   <= rsp_err;
      stg_rdata[0] <= rsp_rdata;
      for (int i = 1; i < RVALID_LATENCY; i++) begin
        stg_vld[i]   <= stg_vld[i-1];
        stg_err[i]   <= stg_err[i-1];
        stg_rdata[i] <= stg_rdata[i-1];
      end
    end
  end

  assign data_rvalid_o = stg_vld[RVALID_LATENCY-1];
  assign data_err_o    = stg_vld[RVALID_LATENCY-1] && stg_err[RVALID_LATENCY-1];
  assign data_rdata_o  = stg_vld[RVALID_LATENCY-1] ? stg_rdata[RVALID_LATENCY-1] : 32'h0;
  assign busy_o        = |stg_vld;

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Bench for ibex_data_mem_responder: three configurations driven by a shared initiator task.
// A scoreboard per instance holds expected responses; a negedge monitor pops and compares.
module tb_ibex_data_mem_responder;

  localparam int          NI = 3;
  localparam int          GD   [NI] = '{0, 3, 0};
  localparam int          LAT  [NI] = '{1, 4, 4};
  localparam int          DEP  [NI] = '{1024, 8, 16};
  localparam logic [31:0] BASE [NI] = '{32'h0000_0000, 32'hFFFF_FFC0, 32'h0000_1000};

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst    [NI];
  logic        req    [NI];
  logic        gnt    [NI];
  logic [31:0] addr   [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] wdata  [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        err    [NI];
  logic        busy   [NI];

  exp_t q0[$], q1[$], q2[$];
  logic [31:0] mm [bit [63:0]];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  exp_t mon_e;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ibex_data_mem_responder #(
      .DEPTH_WORDS(DEP[g]),
      .BASE_ADDR(BASE[g]),
      .RVALID_LATENCY(LAT[g]),
      .GNT_DELAY(GD[g])
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .data_req_i(req[g]),
      .data_gnt_o(gnt[g]),
      .data_addr_i(addr[g]),
      .data_we_i(we[g]),
      .data_be_i(be[g]),
      .data_wdata_i(wdata[g]),
      .data_rvalid_o(rvalid[g]),
      .data_rdata_o(rdata[g]),
      .data_err_o(err[g]),
      .busy_o(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s inst%0d @cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic exp_t q_peek(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_clear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // One initiator transaction. drop>0 holds req that many cycles, releases it one cycle,
  // then requests again so the grant wait must start from scratch.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input int drop);
    int          n;
    logic [31:0] off;
    logic [31:0] word;
    bit          inr;
    bit [63:0]   key;
    exp_t        e;
    addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
    if (drop > 0) begin
      req[k] = 1'b1;
      repeat (drop) begin
        @(negedge clk);
        chk(gnt[k] == 1'b0, "gnt_before_delay", k, 32'(gnt[k]), 32'h0);
        @(posedge clk); #1;
      end
      req[k] = 1'b0;
      @(posedge clk); #1;
    end
    req[k] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt[k]) break;
      n++;
      if (n > 40) begin
        chk(1'b0, "gnt_timeout", k, 32'(n), 32'(GD[k]));
        req[k] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk(n == GD[k], "gnt_delay", k, 32'(n), 32'(GD[k]));
    @(posedge clk); #1;
    // Reference behaviour: rebase, range test, word-granular byte-lane memory.
    off = a - BASE[k];
    inr = 64'(off) < 64'(4 * DEP[k]);
    key = {32'(k), 32'(off >> 2)};
    e.err   = !inr;
    e.rdata = 32'h0;
    e.due   = cyc + LAT[k] - 1;
    if (inr) begin
      word = mm.exists(key) ? mm[key] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        mm[key] = word;
      end else begin
        e.rdata = word;
      end
    end
    q_push(k, e);
    req[k] = 1'b0;
  endtask

  task automatic reset_inst(input int k);
    rst[k] = 1'b1;
    q_clear(k);
    @(posedge clk); #1;
    rst[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int k);
    if (k == 0) begin
      case ($urandom_range(0, 2))
        0: return 32'($urandom_range(0, 63));
        1: return 32'h0FC0 + 32'($urandom_range(0, 127));
        default: return 32'h8000_0000 | 32'($urandom);
      endcase
    end
    return BASE[k] - 32'd16 + 32'($urandom_range(0, 4 * DEP[k] + 31));
  endfunction

  // Monitor: busy must equal "something outstanding"; rvalid pops in grant order on time.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk(busy[k] === (q_size(k) != 0), "busy", k, 32'(busy[k]), 32'(q_size(k) != 0));
      if (rvalid[k] === 1'b1) begin
        if (q_size(k) == 0) begin
          chk(1'b0, "rvalid_unexpected", k, 32'h1, 32'h0);
        end else begin
          mon_e = q_pop(k);
          chk(cyc == mon_e.due, "rvalid_cycle", k, 32'(cyc), 32'(mon_e.due));
          chk(rdata[k] === mon_e.rdata, "rdata", k, rdata[k], mon_e.rdata);
          chk(err[k] === mon_e.err, "err", k, 32'(err[k]), 32'(mon_e.err));
        end
      end else begin
        chk(rvalid[k] === 1'b0 && rdata[k] === 32'h0 && err[k] === 1'b0, "idle_outputs", k,
            rdata[k], 32'h0);
        if (q_size(k) != 0) begin
          mon_e = q_peek(k);
          if (cyc >= mon_e.due) begin
            chk(1'b0, "rvalid_missing", k, 32'(cyc), 32'(mon_e.due));
            mon_e = q_pop(k);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    // Give every word the bench may load a known value.
    for (int w = 0; w < 16; w++) issue(0, 1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    for (int w = 1008; w < 1024; w++) issue(0, 1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    for (int w = 0; w < 8; w++) issue(1, 1'b1, BASE[1] + 32'(w * 4), 4'hF, $urandom, 0);
    for (int w = 0; w < 16; w++) issue(2, 1'b1, BASE[2] + 32'(w * 4), 4'hF, $urandom, 0);

    // Aligned store/load, byte enables, empty byte mask.
    issue(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0);
    issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, 0);
    issue(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 0);
    issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, 0);
    issue(0, 1'b1, 32'h10, 4'b0000, 32'h12345678, 0);
    issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, 0);
    // Misaligned pair: second request raised in the first one's rvalid cycle.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0);
    issue(0, 1'b1, 32'h24, 4'hF, 32'h55667788, 0);
    issue(0, 1'b0, 32'h22, 4'h0, 32'h0, 0);
    issue(0, 1'b0, 32'h24, 4'h0, 32'h0, 0);
    // Out of range, including a store that would alias word 0 if it were not blocked.
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, 0);
    issue(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 0);
    issue(0, 1'b0, 32'h0000, 4'h0, 32'h0, 0);
    issue(0, 1'b0, 32'h0FFC, 4'h0, 32'h0, 0);

    // Delayed grant, long latency, top-of-address-space boundary, restart after dropped req.
    issue(1, 1'b1, BASE[1] + 32'h1C, 4'hF, 32'hA5A5_5A5A, 0);
    issue(1, 1'b0, BASE[1] + 32'h1C, 4'h0, 32'h0, 0);
    issue(1, 1'b0, BASE[1] + 32'h20, 4'h0, 32'h0, 0);
    issue(1, 1'b0, BASE[1] - 32'h4, 4'h0, 32'h0, 0);
    issue(1, 1'b0, BASE[1], 4'h0, 32'h0, 2);
    issue(1, 1'b1, BASE[1] + 32'h8, 4'b1001, 32'h1234_5678, 3);

    // Three loads in flight, then reset before any response: all must vanish.
    issue(2, 1'b0, 32'h1000, 4'h0, 32'h0, 0);
    issue(2, 1'b0, 32'h1004, 4'h0, 32'h0, 0);
    issue(2, 1'b0, 32'h1008, 4'h0, 32'h0, 0);
    reset_inst(2);
    repeat (6) @(posedge clk);
    #1;
    issue(2, 1'b0, 32'h100C, 4'h0, 32'h0, 0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 150; n++) begin
        issue(k, 1'($urandom_range(0, 1)), rand_addr(k), 4'($urandom), $urandom,
              (GD[k] > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, GD[k]) : 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk(q_size(k) == 0, "drain", k, 32'(q_size(k)), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
